// File: rtl/i2c_master_write_sequencer.sv
// Byte-level I2C write-transaction sequencer sitting in front of the bit engine.
// Runs START, address+W, ACK check, N x (data byte, ACK check), STOP, and feeds
// the engine its serial data from an internal shift register.
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   start                   request pulse, only honoured in IDLE
//   slave_addr, byte_count  transaction target and payload length, captured on start
//   tx_data/tx_valid/tx_ready  payload byte stream (tx_ready is combinational on state)
//   busy, done, nack_error  transaction status
//   wb_go/wb_command/wb_data/wb_load/wb_finish  bit-engine handshake
//   rb_go/rb_finish/rb_bit  one-bit ACK reader handshake
module i2c_master_write_sequencer #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       slave_addr,
    input  logic [LEN_W-1:0] byte_count,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic             nack_error,
    output logic             wb_go,
    output logic [2:0]       wb_command,
    output logic             wb_data,
    input  logic             wb_load,
    input  logic             wb_finish,
    output logic             rb_go,
    input  logic             rb_finish,
    input  logic             rb_bit
);

    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_DATA  = 3'b011;
    localparam logic [2:0] CMD_STOP  = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_FETCH,
        S_DATA,
        S_DATA_ACK,
        S_STOP,
        S_DONE
    } state_e;

    // Every engine/reader operation has an ISSUE phase (go high) and a RELEASE phase.
    typedef enum logic {
        PH_ISSUE,
        PH_RELEASE
    } phase_e;

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             nack_error_q, nack_error_d;
    logic             wb_go_q, wb_go_d;
    logic             rb_go_q, rb_go_d;
    logic [2:0]       wb_command_q, wb_command_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            phase_q      <= PH_ISSUE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            nack_error_q <= 1'b0;
            wb_go_q      <= 1'b0;
            rb_go_q      <= 1'b0;
            wb_command_q <= 3'b000;
            shreg_q      <= 8'h00;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            nack_error_q <= nack_error_d;
            wb_go_q      <= wb_go_d;
            rb_go_q      <= rb_go_d;
            wb_command_q <= wb_command_d;
            shreg_q      <= shreg_d;
            remaining_q  <= remaining_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        nack_error_d = nack_error_q;
        wb_go_d      = wb_go_q;
        rb_go_d      = rb_go_q;
        wb_command_d = wb_command_q;
        shreg_d      = shreg_q;
        remaining_d  = remaining_q;

        // Engine consumed a bit; only meaningful while a DATA command is active
        if (wb_load && (wb_command_q == CMD_DATA)) begin
            shreg_d = {shreg_q[6:0], 1'b0};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_START;
                    phase_d      = PH_ISSUE;
                    busy_d       = 1'b1;
                    nack_error_d = 1'b0;
                    shreg_d      = {slave_addr, 1'b0};
                    remaining_d  = byte_count;
                    wb_go_d      = 1'b1;
                    wb_command_d = CMD_START;
                end
            end

            // Engine operations: hold go until finish, then wait for finish to drop
            S_START, S_ADDR, S_DATA, S_STOP: begin
                if (phase_q == PH_ISSUE) begin
                    if (wb_finish) begin
                        wb_go_d = 1'b0;
                        phase_d = PH_RELEASE;
                    end
                end else if (!wb_finish) begin
                    phase_d = PH_ISSUE;
                    case (state_q)
                        S_START: begin
                            state_d      = S_ADDR;
                            wb_go_d      = 1'b1;
                            wb_command_d = CMD_DATA;
                        end
                        S_ADDR: begin
                            state_d = S_ADDR_ACK;
                            rb_go_d = 1'b1;
                        end
                        S_DATA: begin
                            state_d = S_DATA_ACK;
                            rb_go_d = 1'b1;
                        end
                        default: begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    endcase
                end
            end

            // Reader operations: ACK bit is taken on the first cycle finish is high
            S_ADDR_ACK, S_DATA_ACK: begin
                if (phase_q == PH_ISSUE) begin
                    if (rb_finish) begin
                        rb_go_d = 1'b0;
                        phase_d = PH_RELEASE;
                        if (rb_bit) begin
                            nack_error_d = 1'b1;
                        end
                    end
                end else if (!rb_finish) begin
                    phase_d = PH_ISSUE;
                    if (nack_error_q || (remaining_q == '0)) begin
                        state_d      = S_STOP;
                        wb_go_d      = 1'b1;
                        wb_command_d = CMD_STOP;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            // Wait for the next payload byte without touching the bus
            S_FETCH: begin
                if (tx_valid) begin
                    shreg_d      = tx_data;
                    remaining_d  = remaining_q - LEN_W'(1);
                    state_d      = S_DATA;
                    phase_d      = PH_ISSUE;
                    wb_go_d      = 1'b1;
                    wb_command_d = CMD_DATA;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_ready   = (state_q == S_FETCH);
    assign busy       = busy_q;
    assign done       = done_q;
    assign nack_error = nack_error_q;
    assign wb_go      = wb_go_q;
    assign rb_go      = rb_go_q;
    assign wb_command = wb_command_q;
    assign wb_data    = shreg_q[7];

endmodule

// File: tb/tb_i2c_master_write_sequencer.sv
// Bench for i2c_master_write_sequencer: behavioural engine/reader responders,
// a transaction-level reference model, a directed vector table and random traffic.
module tb_i2c_master_write_sequencer;

    localparam int unsigned LEN_W = 8;
    localparam logic [3:0] C_START = 4'd1;
    localparam logic [3:0] C_DATA  = 4'd3;
    localparam logic [3:0] C_STOP  = 4'd4;
    localparam logic [3:0] C_READ  = 4'd8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [6:0]       slave_addr = 7'h00;
    logic [LEN_W-1:0] byte_count = '0;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic             busy;
    logic             done;
    logic             nack_error;
    logic             wb_go;
    logic [2:0]       wb_command;
    logic             wb_data;
    logic             wb_load = 1'b0;
    logic             wb_finish = 1'b0;
    logic             rb_go;
    logic             rb_finish = 1'b0;
    logic             rb_bit = 1'b0;

    i2c_master_write_sequencer #(.LEN_W(LEN_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .slave_addr (slave_addr),
        .byte_count (byte_count),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .nack_error (nack_error),
        .wb_go      (wb_go),
        .wb_command (wb_command),
        .wb_data    (wb_data),
        .wb_load    (wb_load),
        .wb_finish  (wb_finish),
        .rb_go      (rb_go),
        .rb_finish  (rb_finish),
        .rb_bit     (rb_bit)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Current transaction description
    logic [6:0] cur_addr;
    int         cur_count;
    logic [7:0] cur_data[$];
    bit         cur_ack[$];     // index 0: address ACK, i+1: payload byte i; 1 = NACK
    int         tx_hold;
    bit         rand_valid;

    // Observations
    logic [3:0] cmd_log[$];
    logic [7:0] byte_log[$];
    int hs_count, ready_cycles, go_while_ready, done_count;
    int data_ops, cur_bits, read_idx, tx_idx;

    // Model results of the last transaction
    bit m_nack;
    int m_cons;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_nack(input int idx);
        return (idx < cur_ack.size()) ? cur_ack[idx] : 1'b0;
    endfunction

    task automatic clear_logs();
        cmd_log.delete();
        byte_log.delete();
        hs_count = 0; ready_cycles = 0; go_while_ready = 0; done_count = 0;
        data_ops = 0; read_idx = 0; tx_idx = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " busy"},       32'(busy), 0);
        check({tag, " done"},       32'(done), 0);
        check({tag, " nack_error"}, 32'(nack_error), 0);
        check({tag, " tx_ready"},   32'(tx_ready), 0);
        check({tag, " wb_go"},      32'(wb_go), 0);
        check({tag, " rb_go"},      32'(rb_go), 0);
        check({tag, " wb_command"}, 32'(wb_command), 0);
        check({tag, " wb_data"},    32'(wb_data), 0);
    endtask

    // Bit-engine responder: logs commands, serialises DATA bits via wb_load
    initial begin : engine
        int eng_st;
        int eng_lat;
        logic [7:0] sh;
        eng_st = 0; eng_lat = 0; sh = 8'h00;
        forever begin
            @(negedge clock);
            if (reset) begin
                eng_st = 0; wb_finish = 1'b0; wb_load = 1'b0; cur_bits = 0;
            end else begin
                case (eng_st)
                    0: begin
                        wb_load = 1'b0;
                        if (wb_go) begin
                            cmd_log.push_back({1'b0, wb_command});
                            if (wb_command == 3'b011) begin
                                eng_st = 1; cur_bits = 0; sh = 8'h00; data_ops++;
                            end else begin
                                eng_lat = $urandom_range(0, 3);
                                eng_st = 2;
                                // stray load outside DATA must not disturb the address byte
                                if (wb_command == 3'b001) wb_load = 1'b1;
                            end
                        end
                    end
                    1: begin
                        if (cur_bits == 8) begin
                            wb_load = 1'b0;
                            byte_log.push_back(sh);
                            eng_lat = $urandom_range(0, 3);
                            eng_st = 2;
                        end else if ($urandom_range(0, 3) == 0) begin
                            wb_load = 1'b0;
                        end else begin
                            sh = {sh[6:0], wb_data};
                            wb_load = 1'b1;
                            cur_bits++;
                        end
                    end
                    2: begin
                        wb_load = 1'b0;
                        if (eng_lat == 0) begin
                            wb_finish = 1'b1; eng_st = 3;
                        end else begin
                            eng_lat--;
                        end
                    end
                    default: begin
                        if (!wb_go) begin
                            wb_finish = 1'b0; eng_st = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ACK reader responder: answers from cur_ack, then scrambles rb_bit
    initial begin : reader
        int rd_st;
        int rd_lat;
        rd_st = 0; rd_lat = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                rd_st = 0; rb_finish = 1'b0;
            end else begin
                case (rd_st)
                    0: if (rb_go) begin
                        cmd_log.push_back(C_READ);
                        rd_lat = $urandom_range(0, 3);
                        rd_st = 1;
                    end
                    1: begin
                        if (rd_lat == 0) begin
                            rb_finish = 1'b1;
                            rb_bit = is_nack(read_idx);
                            read_idx++;
                            rd_st = 2;
                        end else begin
                            rd_lat--;
                        end
                    end
                    2: if (!rb_go) begin
                        rb_bit = ~rb_bit;
                        rd_st = 3;
                    end
                    default: begin
                        rb_finish = 1'b0;
                        rb_bit = 1'($urandom);
                        rd_st = 0;
                    end
                endcase
            end
        end
    end

    // Payload source and bus monitors
    initial begin : txdrv
        forever begin
            @(negedge clock);
            if (tx_idx < cur_data.size()) begin
                tx_data = cur_data[tx_idx];
                if (tx_ready && tx_hold > 0) begin
                    tx_hold--;
                    tx_valid = 1'b0;
                end else begin
                    tx_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
            end else begin
                tx_valid = 1'b0;
                tx_data = 8'($urandom);
            end
            if (tx_ready) ready_cycles++;
            if (tx_ready && (wb_go || rb_go)) go_while_ready++;
            if (done) done_count++;
            if (!reset && tx_valid && tx_ready) begin
                hs_count++;
                tx_idx++;
            end
        end
    end

    // One full transaction from cur_* against the reference model
    task automatic run_txn(input string name);
        logic [3:0] exp_cmds[$];
        logic [7:0] exp_bytes[$];
        bit nk;
        int cons;
        int waited;
        int bad;
        clear_logs();
        exp_cmds.push_back(C_START);
        exp_cmds.push_back(C_DATA);
        exp_cmds.push_back(C_READ);
        exp_bytes.push_back({cur_addr, 1'b0});
        nk = is_nack(0);
        cons = 0;
        while (!nk && cons < cur_count) begin
            exp_cmds.push_back(C_DATA);
            exp_cmds.push_back(C_READ);
            exp_bytes.push_back(cur_data[cons]);
            cons++;
            nk = is_nack(cons);
        end
        exp_cmds.push_back(C_STOP);
        m_nack = nk;
        m_cons = cons;

        @(negedge clock);
        slave_addr = cur_addr;
        byte_count = 8'(cur_count);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        slave_addr = 7'($urandom);
        byte_count = 8'($urandom);
        check({name, " busy_after_start"}, 32'(busy), 1);
        check({name, " nack_cleared_on_start"}, 32'(nack_error), 0);

        waited = 0;
        while (!done && waited < 20000) begin
            @(negedge clock);
            waited++;
            start = (waited == 3);   // request while busy is ignored
        end
        start = 1'b0;
        check({name, " done_seen"}, 32'(done), 1);
        check({name, " busy_low_with_done"}, 32'(busy), 0);
        @(negedge clock);
        check({name, " done_one_cycle"}, 32'(done), 0);
        check({name, " done_count"}, 32'(done_count), 1);
        check({name, " nack_error"}, 32'(nack_error), 32'(m_nack));
        check({name, " bytes_consumed"}, 32'(hs_count), 32'(m_cons));
        check({name, " go_during_fetch"}, 32'(go_while_ready), 0);

        bad = -1;
        for (int i = 0; i < cmd_log.size() && i < exp_cmds.size(); i++)
            if (bad < 0 && cmd_log[i] !== exp_cmds[i]) bad = i;
        checks++;
        if (bad >= 0 || cmd_log.size() != exp_cmds.size()) begin
            errors++;
            if (bad >= 0)
                $display("FAIL %s cmd_seq: op %0d got %0h, expected %0h", name, bad, cmd_log[bad], exp_cmds[bad]);
            else
                $display("FAIL %s cmd_seq: got %0d ops, expected %0d", name, cmd_log.size(), exp_cmds.size());
        end

        bad = -1;
        for (int i = 0; i < byte_log.size() && i < exp_bytes.size(); i++)
            if (bad < 0 && byte_log[i] !== exp_bytes[i]) bad = i;
        checks++;
        if (bad >= 0 || byte_log.size() != exp_bytes.size()) begin
            errors++;
            if (bad >= 0)
                $display("FAIL %s wb_data_bits: byte %0d got %0h, expected %0h", name, bad, byte_log[bad], exp_bytes[bad]);
            else
                $display("FAIL %s wb_data_bits: got %0d bytes, expected %0d", name, byte_log.size(), exp_bytes.size());
        end
    endtask

    typedef struct {
        logic [6:0] addr;
        int         count;
        logic [7:0] d0, d1, d2;
        logic [7:0] nack_mask;
        int         hold;
        bit         exp_nack;
        int         exp_cons;
        int         exp_ncmds;
        int         exp_ready;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int waited;
        vecs[0] = '{7'h56,   2, 8'hA5, 8'h3C, 8'h00, 8'h00,  0, 1'b0,   2,   8,   2};
        vecs[1] = '{7'h56,   3, 8'h11, 8'h22, 8'h33, 8'h01,  0, 1'b1,   0,   4,   0};
        vecs[2] = '{7'h2A,   3, 8'h11, 8'h22, 8'h33, 8'h02,  0, 1'b1,   1,   6,   1};
        vecs[3] = '{7'h7F,   0, 8'h00, 8'h00, 8'h00, 8'h00,  0, 1'b0,   0,   4,   0};
        vecs[4] = '{7'h12,   1, 8'h5A, 8'h00, 8'h00, 8'h00, 20, 1'b0,   1,   6,  21};
        vecs[5] = '{7'h01, 255, 8'hFF, 8'h00, 8'h81, 8'h00,  0, 1'b0, 255, 514, 255};
        vecs[6] = '{7'h00,   3, 8'h80, 8'h01, 8'hFE, 8'h08,  0, 1'b1,   3,  10,   3};
        tx_hold = 0;
        rand_valid = 1'b0;
        clear_logs();

        repeat (2) @(negedge clock);
        check_zero_outputs("reset_state");
        reset = 1'b0;
        @(negedge clock);
        check_zero_outputs("idle_after_reset");

        // Directed vector table
        for (int v = 0; v < 7; v++) begin
            cur_addr = vecs[v].addr;
            cur_count = vecs[v].count;
            cur_data.delete();
            cur_ack.delete();
            for (int i = 0; i < cur_count; i++) begin
                if (i == 0) cur_data.push_back(vecs[v].d0);
                else if (i == 1) cur_data.push_back(vecs[v].d1);
                else if (i == 2) cur_data.push_back(vecs[v].d2);
                else cur_data.push_back(8'($urandom));
            end
            for (int i = 0; i <= cur_count; i++)
                cur_ack.push_back((i < 8) ? vecs[v].nack_mask[i] : 1'b0);
            tx_hold = vecs[v].hold;
            rand_valid = 1'b0;
            run_txn($sformatf("vec%0d", v));
            check($sformatf("vec%0d tbl_nack", v), 32'(nack_error), 32'(vecs[v].exp_nack));
            check($sformatf("vec%0d tbl_consumed", v), 32'(hs_count), 32'(vecs[v].exp_cons));
            check($sformatf("vec%0d tbl_ops", v), 32'(cmd_log.size()), 32'(vecs[v].exp_ncmds));
            check($sformatf("vec%0d tbl_ready_cycles", v), 32'(ready_cycles), 32'(vecs[v].exp_ready));
        end

        // Reset in the middle of a payload DATA operation
        cur_addr = 7'h33; cur_count = 1;
        cur_data.delete(); cur_data.push_back(8'hC6);
        cur_ack.delete(); cur_ack.push_back(1'b0); cur_ack.push_back(1'b0);
        tx_hold = 0; rand_valid = 1'b0;
        clear_logs();
        @(negedge clock);
        slave_addr = cur_addr; byte_count = 8'(cur_count); start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waited = 0;
        while (!(data_ops == 2 && cur_bits >= 4) && waited < 2000) begin
            @(posedge clock);
            #1;
            waited++;
        end
        check("midreset reached_data", 32'(data_ops == 2 && cur_bits >= 4), 1);
        #1 reset = 1'b1;
        #1 check_zero_outputs("async_reset");
        @(negedge clock);
        slave_addr = 7'h11; byte_count = 8'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("start_in_reset busy", 32'(busy), 0);
        check("start_in_reset wb_go", 32'(wb_go), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_zero_outputs("after_release");
        cur_addr = 7'h4B; cur_count = 1;
        cur_data.delete(); cur_data.push_back(8'h81);
        cur_ack.delete(); cur_ack.push_back(1'b0); cur_ack.push_back(1'b0);
        run_txn("post_reset");

        // Random transactions against the model
        for (int t = 0; t < 30; t++) begin
            cur_addr = 7'($urandom);
            cur_count = $urandom_range(0, 5);
            cur_data.delete();
            cur_ack.delete();
            for (int i = 0; i < cur_count; i++) cur_data.push_back(8'($urandom));
            for (int i = 0; i <= cur_count; i++) cur_ack.push_back($urandom_range(0, 4) == 0);
            tx_hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            rand_valid = 1'b1;
            run_txn($sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
